ysyx_bus_rr_arbiter: RTL and testbench
======================================

# ysyx_bus_rr_arbiter

N-master round-robin arbiter that multiplexes simple request ports onto one 64-bit AXI4 master bus, with one transaction in flight at a time. It succeeds the fixed IFU/LSU two-port arbiter. Masters are granted fairly rather than LSU-first, and reads may be multi-beat INCR bursts. The block sits between the core's fetch, load/store and DMA-style clients and the SoC AXI4 port.

## Interface
- `NM`, default 2: number of request ports (2..8), index 0 = IFU by convention.
- `ADDR_W`, default 32: address width.
- `MAX_LEN`, default 8: maximum read beats per burst (power of 2, ≤256).
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m_valid`  in  NM  per-port request; held high with stable fields until that port's completion.
- `m_we`  in  NM  1 = write, 0 = read.
- `m_addr`  in  NM*ADDR_W  byte address, port i at slice i.
- `m_size`  in  NM*3  AXI size code.
- `m_len`  in  NM*8  beats−1; reads only, writes treat as 0.
- `m_wdata`  in  NM*64  write data, already lane-aligned.
- `m_wstrb`  in  NM*8  byte strobes, already lane-aligned.
- `m_rdata`  out  64  shared read data, valid with any `m_rvalid` bit.
- `m_rvalid`  out  NM  one-hot read beat strobe for the granted port.
- `m_rlast`  out  1  last beat of the current read.
- `m_done`  out  NM  one-hot, one-cycle completion pulse (after last R or B).
- `m_err`  out  1  qualifies `m_done`: any non-OKAY rresp/bresp in the transaction.
- AXI4 master: `io_master_ar{valid,ready,addr,id,len,size,burst}`, `io_master_r{valid,ready,data,resp,last,id}`, `io_master_aw{valid,ready,addr,id,len,size,burst}`, `io_master_w{valid,ready,data,strb,last}`, `io_master_b{valid,ready,resp,id}`, standard widths (data 64, id 4, len 8).

## Operation
- States: IDLE, RD_A, RD_D, WR_A, WR_B.
- IDLE: if any `m_valid`, grant the first requesting port at or after `ptr` (cyclic search). Latch grant index, addr, size, len, and direction. Go to RD_A or WR_A. Grant decision uses the current cycle's `m_valid`.
- RD_A: `arvalid`=1 with latched fields; `arburst`=INCR (01), `arid`=grant index. Go to RD_D on `arready`.
- RD_D: `rready`=1. Each `rvalid` beat drives `m_rdata`=`rdata` and `m_rvalid[g]`=1, and increments the beat counter. On `rlast`, or when counter = len, pulse `m_done[g]`, go to IDLE, and set `ptr`=(g+1) mod NM.
- WR_A: `awvalid` and `wvalid` asserted together with `wlast`=1 and `awlen`=0. Each valid drops independently once its ready is seen; two flags track the AW and W handshakes. Go to WR_B when both are done, including the same-cycle case.
- WR_B: `bready`=1. On `bvalid`, pulse `m_done[g]`, go to IDLE, and update `ptr` as for reads.
- `m_len` > MAX_LEN−1 is clamped to MAX_LEN−1. `m_err` is sticky per transaction and cleared on grant.
- Responses whose `rid`/`bid` does not equal the grant index are still consumed and also set `m_err`.

## Timing
- Reset: state=IDLE, `ptr`=0, counter=0, flags=0. All AXI valids/readies and `m_rvalid`/`m_done`/`m_err`/`m_rlast` are 0. `m_rdata`=0.
- Request → `arvalid`/`awvalid`: 1 cycle (grant registered in IDLE).
- Read beat → `m_rvalid`: 0 cycles (combinational pass-through of R channel while in RD_D).
- `m_done`: the last R beat's cycle for reads; the `bvalid` cycle for writes. The next grant is no earlier than the following cycle.
- `ptr` wraps from NM−1 to 0.
- Deassertion of `m_valid` for a granted port mid-transaction is ignored; the transaction completes.
- `rst` in any state aborts immediately to IDLE; no `m_done` is issued.

## Test plan
- Single read: port 0 reads 0x8000_0000, len 0, size 2. Expect `arvalid` at cycle 1; `arready` at cycle 3; R beat `rdata`=0x1122334455667788 → `m_rvalid`=01, `m_done`=01 on the same cycle, `m_err`=0.
- Burst: port 1 reads with len 3. Expect 4 `m_rvalid[1]` pulses with data D0..D3, `m_rlast` on the 4th, and exactly one `m_done`.
- Fairness: NM=3, all ports hold requests continuously. Expect grant order 0,1,2,0,1,2 and no port skipped.
- Write with skewed handshake: `wready` 2 cycles before `awready`. Expect `wvalid` to drop after its handshake while `awvalid` stays until `awready`. Then `bready`; `bresp`=SLVERR → `m_done` with `m_err`=1.
- Same-cycle AW/W acceptance: go to WR_B the next cycle; `m_done` on `bvalid`.
- Reset mid-RD_D after 2 of 4 beats: all outputs return to 0 the next cycle, `ptr`=0, and a new request from port 1 is granted normally.

Source files
------------

// File: rtl/ysyx_bus_rr_arbiter.sv
// ysyx_bus_rr_arbiter: round-robin arbiter of NM request ports onto one AXI4 master, one transaction in flight
module ysyx_bus_rr_arbiter #(
  parameter int NM = 2,
  parameter int ADDR_W = 32,
  parameter int MAX_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NM-1:0]        m_valid,
  input  logic [NM-1:0]        m_we,
  input  logic [NM*ADDR_W-1:0] m_addr,
  input  logic [NM*3-1:0]      m_size,
  input  logic [NM*8-1:0]      m_len,
  input  logic [NM*64-1:0]     m_wdata,
  input  logic [NM*8-1:0]      m_wstrb,
  output logic [63:0]          m_rdata,
  output logic [NM-1:0]        m_rvalid,
  output logic                 m_rlast,
  output logic [NM-1:0]        m_done,
  output logic                 m_err,
  output logic                 io_master_arvalid,
  input  logic                 io_master_arready,
  output logic [ADDR_W-1:0]    io_master_araddr,
  output logic [3:0]           io_master_arid,
  output logic [7:0]           io_master_arlen,
  output logic [2:0]           io_master_arsize,
  output logic [1:0]           io_master_arburst,
  input  logic                 io_master_rvalid,
  output logic                 io_master_rready,
  input  logic [63:0]          io_master_rdata,
  input  logic [1:0]           io_master_rresp,
  input  logic                 io_master_rlast,
  input  logic [3:0]           io_master_rid,
  output logic                 io_master_awvalid,
  input  logic                 io_master_awready,
  output logic [ADDR_W-1:0]    io_master_awaddr,
  output logic [3:0]           io_master_awid,
  output logic [7:0]           io_master_awlen,
  output logic [2:0]           io_master_awsize,
  output logic [1:0]           io_master_awburst,
  output logic                 io_master_wvalid,
  input  logic                 io_master_wready,
  output logic [63:0]          io_master_wdata,
  output logic [7:0]           io_master_wstrb,
  output logic                 io_master_wlast,
  input  logic                 io_master_bvalid,
  output logic                 io_master_bready,
  input  logic [1:0]           io_master_bresp,
  input  logic [3:0]           io_master_bid
);
  localparam int PW = $clog2(NM);
  localparam logic [2:0] S_IDLE = 3'd0, S_RDA = 3'd1, S_RDD = 3'd2, S_WRA = 3'd3, S_WRB = 3'd4;
  localparam logic [7:0] LMAX = 8'(MAX_LEN - 1);
  logic [2:0] state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, g_q, g_d, gnt, cand;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0] size_q, size_d;
  logic [7:0] len_q, len_d, cnt_q, cnt_d, req_len;
  logic awd_q, awd_d, wd_q, wd_d, err_q, err_d, found;
  logic [NM-1:0] g_oh;
  logic [3:0] g_id;
  logic r_beat, r_end, r_bad, b_beat, b_bad, aw_ok, w_ok;
  logic [ADDR_W-1:0] addr_a [NM];
  logic [2:0] size_a [NM];
  logic [7:0] len_a [NM];
  logic [63:0] wdata_a [NM];
  logic [7:0] wstrb_a [NM];
  for (genvar i = 0; i < NM; i++) begin : g_unpack
    assign addr_a[i] = m_addr[i*ADDR_W +: ADDR_W];
    assign size_a[i] = m_size[i*3 +: 3];
    assign len_a[i] = m_len[i*8 +: 8];
    assign wdata_a[i] = m_wdata[i*64 +: 64];
    assign wstrb_a[i] = m_wstrb[i*8 +: 8];
  end
  // cyclic search for the first requester at or after ptr
  always_comb begin
    gnt = '0;
    cand = '0;
    found = 1'b0;
    for (int k = 0; k < NM; k++) begin
      cand = PW'((int'(ptr_q) + k) % NM);
      if (!found && m_valid[cand]) begin
        found = 1'b1;
        gnt = cand;
      end
    end
  end
  assign g_oh = NM'(1) << g_q;
  assign g_id = 4'(g_q);
  assign req_len = m_we[gnt] ? 8'd0 : (len_a[gnt] > LMAX ? LMAX : len_a[gnt]);
  assign r_beat = state_q == S_RDD && io_master_rvalid;
  assign r_end = r_beat && (io_master_rlast || cnt_q == len_q);
  assign r_bad = io_master_rresp != 2'b00 || io_master_rid != g_id;
  assign b_beat = state_q == S_WRB && io_master_bvalid;
  assign b_bad = io_master_bresp != 2'b00 || io_master_bid != g_id;
  assign aw_ok = awd_q || io_master_awready;
  assign w_ok = wd_q || io_master_wready;
  assign io_master_arvalid = state_q == S_RDA;
  assign io_master_araddr = addr_q;
  assign io_master_arid = g_id;
  assign io_master_arlen = len_q;
  assign io_master_arsize = size_q;
  assign io_master_arburst = 2'b01;
  assign io_master_rready = state_q == S_RDD;
  assign io_master_awvalid = state_q == S_WRA && !awd_q;
  assign io_master_awaddr = addr_q;
  assign io_master_awid = g_id;
  assign io_master_awlen = 8'd0;
  assign io_master_awsize = size_q;
  assign io_master_awburst = 2'b01;
  assign io_master_wvalid = state_q == S_WRA && !wd_q;
  assign io_master_wdata = wdata_a[g_q];
  assign io_master_wstrb = wstrb_a[g_q];
  assign io_master_wlast = 1'b1;
  assign io_master_bready = state_q == S_WRB;
  assign m_rdata = r_beat ? io_master_rdata : 64'd0;
  assign m_rvalid = r_beat ? g_oh : '0;
  assign m_rlast = r_end;
  assign m_done = (r_end || b_beat) ? g_oh : '0;
  assign m_err = err_q || (r_beat && r_bad) || (b_beat && b_bad);
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    g_d = g_q;
    addr_d = addr_q;
    size_d = size_q;
    len_d = len_q;
    cnt_d = cnt_q;
    awd_d = awd_q;
    wd_d = wd_q;
    err_d = err_q;
    if (state_q == S_IDLE && found) begin
      state_d = m_we[gnt] ? S_WRA : S_RDA;
      g_d = gnt;
      addr_d = addr_a[gnt];
      size_d = size_a[gnt];
      len_d = req_len;
      cnt_d = 8'd0;
      awd_d = 1'b0;
      wd_d = 1'b0;
      err_d = 1'b0;
    end
    if (state_q == S_RDA && io_master_arready) state_d = S_RDD;
    if (r_beat) begin
      cnt_d = cnt_q + 8'd1;
      err_d = err_q || r_bad;
    end
    // AW and W complete independently; either may land first or both together
    if (state_q == S_WRA) begin
      awd_d = aw_ok;
      wd_d = w_ok;
      state_d = (aw_ok && w_ok) ? S_WRB : S_WRA;
    end
    if (b_beat) err_d = err_q || b_bad;
    if (r_end || b_beat) begin
      state_d = S_IDLE;
      ptr_d = g_q == PW'(NM - 1) ? '0 : g_q + PW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q <= '0;
      g_q <= '0;
      addr_q <= '0;
      size_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      awd_q <= 1'b0;
      wd_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      g_q <= g_d;
      addr_q <= addr_d;
      size_q <= size_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      awd_q <= awd_d;
      wd_q <= wd_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_ysyx_bus_rr_arbiter.sv
// tb_ysyx_bus_rr_arbiter: directed stimulus with a queue-based scoreboard on m_rvalid/m_done
module tb_ysyx_bus_rr_arbiter;
  localparam int NM = 3;
  logic clk = 1'b0;
  logic rst;
  logic [NM-1:0] m_valid, m_we, m_rvalid, m_done;
  logic [NM*32-1:0] m_addr;
  logic [NM*3-1:0] m_size;
  logic [NM*8-1:0] m_len, m_wstrb;
  logic [NM*64-1:0] m_wdata;
  logic [63:0] m_rdata;
  logic m_rlast, m_err;
  logic arvalid, arready, rvalid, rready, rlast, awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] araddr, awaddr;
  logic [3:0] arid, rid, awid, bid;
  logic [7:0] arlen, awlen, wstrb;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst, rresp, bresp;
  logic [63:0] rdata, wdata;
  typedef struct {bit done; int p; logic [63:0] d; bit last; bit err;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int n;

  ysyx_bus_rr_arbiter #(.NM(NM), .ADDR_W(32), .MAX_LEN(8)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_size(m_size), .m_len(m_len),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
    .m_rlast(m_rlast), .m_done(m_done), .m_err(m_err),
    .io_master_arvalid(arvalid), .io_master_arready(arready), .io_master_araddr(araddr),
    .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize), .io_master_arburst(arburst),
    .io_master_rvalid(rvalid), .io_master_rready(rready), .io_master_rdata(rdata),
    .io_master_rresp(rresp), .io_master_rlast(rlast), .io_master_rid(rid),
    .io_master_awvalid(awvalid), .io_master_awready(awready), .io_master_awaddr(awaddr),
    .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize), .io_master_awburst(awburst),
    .io_master_wvalid(wvalid), .io_master_wready(wready), .io_master_wdata(wdata),
    .io_master_wstrb(wstrb), .io_master_wlast(wlast),
    .io_master_bvalid(bvalid), .io_master_bready(bready), .io_master_bresp(bresp), .io_master_bid(bid)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] rd_data(input int p, input int i);
    return 64'h1122334455667788 + 64'(i) * 64'h0101010101010101 + (64'(p) << 56);
  endfunction

  task automatic push(input bit dn, input int p, input logic [63:0] d, input bit last, input bit err);
    exp_t e;
    e.done = dn;
    e.p = p;
    e.d = d;
    e.last = last;
    e.err = err;
    exp_q.push_back(e);
  endtask

  // monitor: every DUT beat or completion consumes one scoreboard entry
  always @(negedge clk) begin
    if (!rst && |m_rvalid) begin
      if (exp_q.size() == 0) check("unexpected_beat", 64'(m_rvalid), 64'd0);
      else begin
        mon_e = exp_q.pop_front();
        check("rvalid", 64'(m_rvalid), mon_e.done ? 64'd0 : 64'd1 << mon_e.p);
        check("rdata", m_rdata, mon_e.d);
        check("rlast", 64'(m_rlast), 64'(mon_e.last));
      end
    end
    if (!rst && |m_done) begin
      if (exp_q.size() == 0) check("unexpected_done", 64'(m_done), 64'd0);
      else begin
        mon_e = exp_q.pop_front();
        check("done", 64'(m_done), mon_e.done ? 64'd1 << mon_e.p : 64'd0);
        check("err", 64'(m_err), 64'(mon_e.err));
      end
    end
  end

  task automatic clear_axi();
    arready = 0; rvalid = 0; rdata = '0; rresp = 0; rlast = 0; rid = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    m_valid = '0;
    clear_axi();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic req(input int p, input bit we, input logic [7:0] len);
    m_valid[p] = 1'b1;
    m_we[p] = we;
    m_addr[p*32 +: 32] = 32'h8000_0000 + 32'(p) * 32'h100;
    m_size[p*3 +: 3] = 3'(2 + p);
    m_len[p*8 +: 8] = len;
    m_wdata[p*64 +: 64] = 64'hA5A5_0000_0000_0000 | 64'(p);
    m_wstrb[p*8 +: 8] = 8'hFF >> p;
  endtask

  task automatic wait_hi(input bit aw, input string nm, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(aw ? awvalid : arvalid) && cyc < 20);
    check(nm, 64'(aw ? awvalid : arvalid), 64'd1);
  endtask

  task automatic serve_rd(input int p, input int nb, input int give, input int ard, input bit drv_last,
                          input logic [3:0] r_id, input logic [1:0] resp, input bit hold, output int cyc);
    wait_hi(0, "arvalid", cyc);
    check("arid", 64'(arid), 64'(p));
    check("araddr", 64'(araddr), 64'(32'h8000_0000 + 32'(p) * 32'h100));
    check("arlen", 64'(arlen), 64'(nb - 1));
    check("arsize", 64'(arsize), 64'(2 + p));
    check("arburst", 64'(arburst), 64'd1);
    repeat (ard) begin
      @(posedge clk);
      #1;
    end
    arready = 1;
    @(posedge clk);
    #1 arready = 0;
    if (!hold) m_valid = '0;
    for (int i = 0; i < give; i++) begin
      push(0, p, rd_data(p, i), i == nb - 1, 0);
      if (i == nb - 1) push(1, p, '0, 0, resp != 2'b00 || r_id != 4'(p));
      rvalid = 1;
      rdata = rd_data(p, i);
      rlast = drv_last && i == nb - 1;
      rid = r_id;
      rresp = resp;
      @(posedge clk);
      #1;
    end
    rvalid = 0;
    rlast = 0;
  endtask

  task automatic serve_wr(input int p, input bit skew, input logic [1:0] resp);
    int cyc;
    wait_hi(1, "awvalid", cyc);
    check("awid", 64'(awid), 64'(p));
    check("awaddr", 64'(awaddr), 64'(32'h8000_0000 + 32'(p) * 32'h100));
    check("awlen", 64'(awlen), 64'd0);
    check("awburst", 64'(awburst), 64'd1);
    check("wvalid", 64'(wvalid), 64'd1);
    check("wdata", wdata, 64'hA5A5_0000_0000_0000 | 64'(p));
    check("wstrb", 64'(wstrb), 64'(8'hFF >> p));
    check("wlast", 64'(wlast), 64'd1);
    if (skew) begin
      wready = 1;
      @(posedge clk);
      #1 wready = 0;
      m_valid = '0;
      @(negedge clk);
      check("wvalid_drop", 64'(wvalid), 64'd0);
      check("awvalid_hold", 64'(awvalid), 64'd1);
      @(negedge clk);
      check("awvalid_hold2", 64'(awvalid), 64'd1);
      awready = 1;
    end else begin
      awready = 1;
      wready = 1;
    end
    @(posedge clk);
    #1 awready = 0;
    wready = 0;
    m_valid = '0;
    @(negedge clk);
    check("bready", 64'(bready), 64'd1);
    check("aw_w_idle", 64'({awvalid, wvalid}), 64'd0);
    @(posedge clk);
    #1 push(1, p, '0, 0, resp != 2'b00);
    bvalid = 1;
    bresp = resp;
    bid = 4'(p);
    @(posedge clk);
    #1 bvalid = 0;
  endtask

  initial begin
    m_we = '0; m_addr = '0; m_size = '0; m_len = '0; m_wdata = '0; m_wstrb = '0;
    do_reset();
    @(negedge clk);
    check("rst_axi_valids", 64'({arvalid, awvalid, wvalid, rready, bready}), 64'd0);
    check("rst_rvalid", 64'(m_rvalid), 64'd0);
    check("rst_done", 64'(m_done), 64'd0);
    check("rst_err_rlast", 64'({m_err, m_rlast}), 64'd0);
    check("rst_rdata", m_rdata, 64'd0);
    @(posedge clk);
    #1 req(0, 0, 0);
    @(negedge clk);
    check("ar_cycle0", 64'(arvalid), 64'd0);
    serve_rd(0, 1, 1, 2, 1, 4'd0, 2'b00, 0, n);
    check("ar_latency", 64'(n), 64'd1);
    req(1, 0, 3);
    serve_rd(1, 4, 4, 0, 1, 4'd1, 2'b00, 0, n);
    // abort mid-burst: port 0 wins (ptr=2, only port 0 asks), 2 of 4 beats, then reset
    req(0, 0, 3);
    serve_rd(0, 4, 2, 0, 1, 4'd0, 2'b00, 0, n);
    rvalid = 1;
    rdata = rd_data(0, 2);
    rst = 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_rvalid", 64'(m_rvalid), 64'd0);
    check("abort_done", 64'(m_done), 64'd0);
    check("abort_rdata", m_rdata, 64'd0);
    check("abort_flags", 64'({m_rlast, m_err, rready, arvalid}), 64'd0);
    rst = 0;
    rvalid = 0;
    req(1, 0, 0);
    req(2, 0, 0);
    serve_rd(1, 1, 1, 0, 1, 4'd1, 2'b00, 0, n);
    req(2, 0, 20);
    serve_rd(2, 8, 8, 1, 0, 4'd2, 2'b00, 0, n);
    req(0, 0, 0);
    serve_rd(0, 1, 1, 0, 1, 4'd5, 2'b00, 0, n);
    req(1, 1, 5);
    serve_wr(1, 1, 2'b10);
    req(2, 1, 0);
    serve_wr(2, 0, 2'b00);
    req(0, 0, 0);
    req(1, 0, 0);
    req(2, 0, 0);
    for (int k = 0; k < 6; k++) serve_rd(k % 3, 1, 1, 0, 1, 4'(k % 3), 2'b00, 1, n);
    m_valid = '0;
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
